// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: serializer state encoding and codeword bit positions.
// The downstream decoder imports the same package so both sides agree on bit placement.
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int ERR_W  = 3;
    localparam int CW_W   = 7;

    // Codeword bit index = Hamming position - 1
    localparam int POS_P1 = 0;
    localparam int POS_P2 = 1;
    localparam int POS_D0 = 2;
    localparam int POS_P4 = 3;
    localparam int POS_D1 = 4;
    localparam int POS_D2 = 5;
    localparam int POS_D3 = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/hamming74_encode.sv
// Combinational Hamming(7,4) encoder with optional single-bit error injection.
// err_pos = k (1..7) flips Hamming position k; err_pos = 0 leaves the codeword clean.
module hamming74_encode
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [ERR_W-1:0]  err_pos,
    output logic [CW_W-1:0]   cw
);

    logic [CW_W-1:0] clean;
    logic [CW_W-1:0] flip_mask;

    // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
    always_comb begin
        clean         = '0;
        clean[POS_P1] = data[0] ^ data[1] ^ data[3];
        clean[POS_P2] = data[0] ^ data[2] ^ data[3];
        clean[POS_D0] = data[0];
        clean[POS_P4] = data[1] ^ data[2] ^ data[3];
        clean[POS_D1] = data[1];
        clean[POS_D2] = data[2];
        clean[POS_D3] = data[3];

        flip_mask = '0;
        if (err_pos != '0)
            flip_mask = 7'd1 << (err_pos - 3'd1);
    end

    assign cw = clean ^ flip_mask;

endmodule

// File: rtl/hamming_tx_serializer.sv
// Encodes a nibble into a Hamming(7,4) codeword and sends it as a UART-like frame:
// start bit (0), seven codeword bits LSB first, stop bit (1), each BIT_CYCLES clocks long.
module hamming_tx_serializer
    import hamming_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ERR_W-1:0]  in_err_pos,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CW_W-1:0]   cw_out,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [7:0] LAST_CNT = 8'(BIT_CYCLES - 1);
    localparam logic [2:0] LAST_BIT = 3'(CW_W - 1);

    tx_state_t       state;
    logic [7:0]      cnt;
    logic [2:0]      bit_idx;
    logic [CW_W-1:0] cw_enc;

    hamming74_encode u_encode (
        .data    (in_data),
        .err_pos (in_err_pos),
        .cw      (cw_enc)
    );

    // All outputs are registered alongside the state so they change on the same edge.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            cw_out     <= '0;
            tx         <= 1'b1;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        cw_out   <= cw_enc;
                        state    <= START;
                        cnt      <= '0;
                        tx       <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == LAST_CNT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= cw_out[0];
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            state      <= STOP;
                            tx         <= 1'b1;
                            // A one-cycle stop bit is its own last cycle
                            frame_done <= (LAST_CNT == 8'd0);
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cw_out[bit_idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt      <= '0;
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt        <= cnt + 8'd1;
                        frame_done <= (cnt == LAST_CNT - 8'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Self-checking bench for hamming_tx_serializer with BIT_CYCLES=4 and BIT_CYCLES=1 instances.
// Expected codewords come from a position-based Hamming model or from known-answer literals.
module tb_hamming_tx_serializer;

    localparam int BC_A = 4;
    localparam int BC_B = 1;

    logic       clk = 1'b0;
    logic       rst;

    logic [3:0] in_data_a, in_data_b;
    logic [2:0] in_err_pos_a, in_err_pos_b;
    logic       in_valid_a, in_valid_b;
    logic       in_ready_a, in_ready_b;
    logic [6:0] cw_out_a, cw_out_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;
    logic       frame_done_a, frame_done_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hamming_tx_serializer #(.BIT_CYCLES(BC_A)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data_a),
        .in_err_pos (in_err_pos_a),
        .in_valid   (in_valid_a),
        .in_ready   (in_ready_a),
        .cw_out     (cw_out_a),
        .tx         (tx_a),
        .busy       (busy_a),
        .frame_done (frame_done_a)
    );

    hamming_tx_serializer #(.BIT_CYCLES(BC_B)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data_b),
        .in_err_pos (in_err_pos_b),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .cw_out     (cw_out_b),
        .tx         (tx_b),
        .busy       (busy_b),
        .frame_done (frame_done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Classic Hamming construction: data at non-power-of-two positions,
    // parity at position p covers every other position whose index has bit p set.
    function automatic logic [6:0] ref_codeword(input logic [3:0] d, input logic [2:0] e);
        logic [7:0] word;
        int         p;
        word    = '0;
        word[3] = d[0];
        word[5] = d[1];
        word[6] = d[2];
        word[7] = d[3];
        for (int b = 0; b < 3; b++) begin
            p = 1 << b;
            for (int pos = 1; pos < 8; pos++)
                if ((pos & p) != 0 && pos != p)
                    word[p] = word[p] ^ word[pos];
        end
        if (e != 3'd0)
            word[e] = ~word[e];
        return word[7:1];
    endfunction

    // Serial slot s of a frame: 0 = start, 1..7 = codeword bits LSB first, 8 = stop
    function automatic logic exp_tx(input logic [6:0] cw, input int s);
        if (s == 0) return 1'b0;
        if (s == 8) return 1'b1;
        return cw[s-1];
    endfunction

    task automatic wait_ready_a();
        int n = 0;
        while (!in_ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait_a", 32'(in_ready_a), 32'd1);
    endtask

    task automatic wait_ready_b();
        int n = 0;
        while (!in_ready_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait_b", 32'(in_ready_b), 32'd1);
    endtask

    // One frame on dut_a; inputs are scrambled during the frame to show they are ignored.
    task automatic run_frame_a(input logic [3:0] d, input logic [2:0] e, input logic [6:0] exp_cw);
        wait_ready_a();
        in_data_a    = d;
        in_err_pos_a = e;
        in_valid_a   = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 9*BC_A; c++) begin
            check($sformatf("a_tx_c%0d", c), 32'(tx_a), 32'(exp_tx(exp_cw, (c-1)/BC_A)));
            check($sformatf("a_cw_c%0d", c), 32'(cw_out_a), 32'(exp_cw));
            check($sformatf("a_busy_c%0d", c), 32'(busy_a), 32'd1);
            check($sformatf("a_ready_c%0d", c), 32'(in_ready_a), 32'd0);
            check($sformatf("a_done_c%0d", c), 32'(frame_done_a), 32'(c == 9*BC_A));
            in_valid_a   = (c < 9*BC_A) ? 1'($urandom) : 1'b0;
            in_data_a    = 4'($urandom);
            in_err_pos_a = 3'($urandom);
            @(negedge clk);
        end
        check("a_idle_tx", 32'(tx_a), 32'd1);
        check("a_idle_busy", 32'(busy_a), 32'd0);
        check("a_idle_ready", 32'(in_ready_a), 32'd1);
        check("a_idle_done", 32'(frame_done_a), 32'd0);
        check("a_idle_cw", 32'(cw_out_a), 32'(exp_cw));
    endtask

    task automatic run_frame_b(input logic [3:0] d, input logic [2:0] e, input logic [6:0] exp_cw);
        wait_ready_b();
        in_data_b    = d;
        in_err_pos_b = e;
        in_valid_b   = 1'b1;
        @(negedge clk);
        in_valid_b = 1'b0;
        for (int c = 1; c <= 9*BC_B; c++) begin
            check($sformatf("b_tx_c%0d", c), 32'(tx_b), 32'(exp_tx(exp_cw, (c-1)/BC_B)));
            check($sformatf("b_cw_c%0d", c), 32'(cw_out_b), 32'(exp_cw));
            check($sformatf("b_busy_c%0d", c), 32'(busy_b), 32'd1);
            check($sformatf("b_done_c%0d", c), 32'(frame_done_b), 32'(c == 9*BC_B));
            in_data_b = 4'($urandom);
            @(negedge clk);
        end
        check("b_idle_ready", 32'(in_ready_b), 32'd1);
        check("b_idle_tx", 32'(tx_b), 32'd1);
        check("b_idle_done", 32'(frame_done_b), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] d, da, db;
        logic [2:0] e;
        logic       prev_busy;
        int         start2;

        rst          = 1'b1;
        in_data_a    = '0; in_err_pos_a = '0; in_valid_a = 1'b0;
        in_data_b    = '0; in_err_pos_b = '0; in_valid_b = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_a_tx", 32'(tx_a), 32'd1);
        check("rst_a_ready", 32'(in_ready_a), 32'd1);
        check("rst_a_busy", 32'(busy_a), 32'd0);
        check("rst_a_done", 32'(frame_done_a), 32'd0);
        check("rst_a_cw", 32'(cw_out_a), 32'd0);
        check("rst_b_tx", 32'(tx_b), 32'd1);
        check("rst_b_ready", 32'(in_ready_b), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer frames
        run_frame_a(4'b1011, 3'd0, 7'b1010101);
        run_frame_a(4'b0000, 3'd0, 7'b0000000);
        run_frame_a(4'b1111, 3'd0, 7'b1111111);
        run_frame_a(4'b1011, 3'd3, 7'b1010001);
        run_frame_a(4'b1011, 3'd7, 7'b0010101);

        // Randomized frames against the reference model
        for (int i = 0; i < 8; i++) begin
            d = 4'($urandom);
            e = 3'($urandom_range(0, 7));
            run_frame_a(d, e, ref_codeword(d, e));
        end

        // Back-to-back frames with in_valid held high
        wait_ready_a();
        da           = 4'($urandom);
        db           = ~da;
        in_data_a    = da;
        in_err_pos_a = 3'd0;
        in_valid_a   = 1'b1;
        @(negedge clk);
        in_data_a = db;
        prev_busy = 1'b1;
        start2    = -1;
        for (int c = 1; c <= 60; c++) begin
            if (!prev_busy && busy_a) begin
                start2 = c;
                break;
            end
            check($sformatf("b2b_cw1_c%0d", c), 32'(cw_out_a), 32'(ref_codeword(da, 3'd0)));
            prev_busy = busy_a;
            @(negedge clk);
        end
        check("b2b_start2_cycle", 32'(start2), 32'd38);
        check("b2b_start2_tx", 32'(tx_a), 32'd0);
        check("b2b_cw2", 32'(cw_out_a), 32'(ref_codeword(db, 3'd0)));
        in_valid_a = 1'b0;
        wait_ready_a();

        // Reset mid-DATA aborts the frame
        in_data_a  = 4'b1111;
        in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        repeat (11) @(negedge clk);
        check("mid_busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx", 32'(tx_a), 32'd1);
        check("abort_ready", 32'(in_ready_a), 32'd1);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_cw", 32'(cw_out_a), 32'd0);
        check("abort_done", 32'(frame_done_a), 32'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check($sformatf("abort_quiet_done_c%0d", c), 32'(frame_done_a), 32'd0);
            check($sformatf("abort_quiet_tx_c%0d", c), 32'(tx_a), 32'd1);
        end

        // Reset beats a simultaneous handshake
        run_frame_a(4'b1111, 3'd0, 7'b1111111);
        rst          = 1'b1;
        in_data_a    = 4'b1011;
        in_valid_a   = 1'b1;
        @(negedge clk);
        check("rst_hs_busy", 32'(busy_a), 32'd0);
        check("rst_hs_cw", 32'(cw_out_a), 32'd0);
        check("rst_hs_tx", 32'(tx_a), 32'd1);
        rst        = 1'b0;
        in_valid_a = 1'b0;
        @(negedge clk);

        // BIT_CYCLES=1 instance: nine-clock frames
        run_frame_b(4'b1011, 3'd0, 7'b1010101);
        for (int i = 0; i < 4; i++) begin
            d = 4'($urandom);
            e = 3'($urandom_range(0, 7));
            run_frame_b(d, e, ref_codeword(d, e));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hamming_tx_serializer.md
HAMMING_TX_SERIALIZER -- requirements
Module: hamming_tx_serializer

Interface
REQ-001 SHALL have parameter: BIT_CYCLES, 4, clocks per serial bit period (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: in_data  input  4  data nibble d[3:0] to encode.
REQ-005 SHALL have port: in_err_pos  input  3  error-injection position 1..7; 0 = no injection.
REQ-006 SHALL have port: in_valid  input  1  upstream offers in_data/in_err_pos.
REQ-007 SHALL have port: in_ready  output  1  block can accept a nibble this cycle.
REQ-008 SHALL have port: cw_out  output  7  registered codeword of the frame in flight or last sent, after injection.
REQ-009 SHALL have port: tx  output  1  serial line; idles high.
REQ-010 SHALL have port: busy  output  1  high while a frame is in flight.
REQ-011 SHALL have port: frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Function
REQ-012 SHALL encode Hamming(7,4), cw bit index i-1 = position i: cw[0]=p1, cw[1]=p2, cw[2]=d0, cw[3]=p4, cw[4]=d1, cw[5]=d2, cw[6]=d3.
REQ-013 SHALL compute p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3 (even parity).
REQ-014 SHALL, when in_err_pos=k (1..7), invert cw bit k-1 after encoding; k=0 leaves codeword unchanged.
REQ-015 SHALL accept a transfer only on a rising edge with in_valid=1 and in_ready=1; at that edge cw_out loads the (possibly corrupted) codeword.
REQ-016 SHALL drive in_ready=1 only in state IDLE; in_ready is a registered function of state, never of in_valid.
REQ-017 SHALL implement states IDLE -> START -> DATA -> STOP -> IDLE.
REQ-018 SHALL hold every state except IDLE for exactly BIT_CYCLES clocks per bit, counted by a bit-period counter reset at each bit boundary.
REQ-019 SHALL drive tx=1 in IDLE, tx=0 in START, tx=cw_out[bit_idx] in DATA (bit_idx 0..6, LSB first, 7 bits), and tx=1 in STOP.
REQ-020 SHALL enter START on the edge that accepts a transfer, so tx is low in the first cycle after acceptance.
REQ-021 SHALL take exactly 9*BIT_CYCLES clocks per frame from the first START cycle to the last STOP cycle.
REQ-022 SHALL assert frame_done in the last STOP cycle only, and return to IDLE (in_ready=1) on the following cycle.
REQ-023 SHALL drive busy=1 exactly when state is not IDLE.
REQ-024 SHALL ignore in_valid, in_data and in_err_pos while busy; cw_out is stable for the whole frame.
REQ-025 SHALL allow minimum frame spacing of one IDLE cycle: if in_valid is held high, the next frame starts 9*BIT_CYCLES+1 clocks after the previous one.
REQ-026 SHALL wrap bit_idx from 6 to STOP, never to 0; no eighth data bit is ever emitted.

Reset
REQ-027 SHALL, on any edge with rst=1, set state=IDLE, tx=1, in_ready=1, busy=0, frame_done=0, cw_out=7'b0000000, counters=0.
REQ-028 SHALL give rst priority over a simultaneous in_valid handshake; no transfer is accepted on a reset edge.
REQ-029 SHALL abort an in-flight frame on reset mid-operation, with tx high from the next cycle and no frame_done pulse.

Structure
REQ-030 SHALL place the state encoding (IDLE, START, DATA, STOP) and the codeword position constants in a shared package, hamming_pkg, reused by the downstream decoder.
REQ-031 SHALL implement the encoder and injection as one combinational sub-module, hamming74_encode (4-bit data, 3-bit error position in; 7-bit codeword out), instantiated once.
REQ-032 SHALL keep all sequential state in hamming_tx_serializer; tx, in_ready, busy and frame_done are registered outputs.

Verification
REQ-033 SHALL check: in_data=4'b1011, in_err_pos=0, BIT_CYCLES=4 -> cw_out=7'b1010101; tx sequence 0,1,0,1,0,1,0,1,1, each bit held 4 clocks; frame_done at clock 36.
REQ-034 SHALL check: in_data=4'b0000 -> cw_out=7'b0000000; in_data=4'b1111 -> cw_out=7'b1111111.
REQ-035 SHALL check: in_data=4'b1011, in_err_pos=3'b011 -> cw_out=7'b1010001; in_err_pos=3'b111 -> cw_out=7'b0010101.
REQ-036 SHALL check: in_valid held high through two frames with different data -> second START begins exactly 37 clocks after the first; data changes during frame 1 do not alter cw_out.
REQ-037 SHALL check: rst asserted for one cycle mid-DATA -> next cycle tx=1, in_ready=1, busy=0, cw_out=0; no frame_done pulse.
REQ-038 SHALL check: BIT_CYCLES=1 -> the frame spans 9 clocks, with each serial bit held for exactly one cycle.
